// File: rtl/oldland_bus_arbiter.sv
// Two-master arbiter sharing one memory bus between instruction fetch and data ports.
// Optional macro OLDLAND_ARB_ROUND_ROBIN_EN alternates simultaneous grants instead of favouring data.
module oldland_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_access,
    input  logic [29:0] i_addr,
    output logic [31:0] i_data,
    output logic        i_ack,
    output logic        i_error,
    input  logic        d_access,
    input  logic [29:0] d_addr,
    input  logic        d_wr_en,
    input  logic [3:0]  d_bytesel,
    input  logic [31:0] d_wr_val,
    output logic [31:0] d_data,
    output logic        d_ack,
    output logic        d_error,
    output logic        m_access,
    output logic [29:0] m_addr,
    output logic        m_wr_en,
    output logic [3:0]  m_bytesel,
    output logic [31:0] m_wr_val,
    input  logic [31:0] m_data,
    input  logic        m_ack,
    input  logic        m_error
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] I_BUS = 2'd1;
    localparam logic [1:0] D_BUS = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [15:0] timeout_cnt;
    logic        pick_d;
    logic        bus_done;
    logic        bus_err;
    logic [31:0] bus_data;

`ifdef OLDLAND_ARB_ROUND_ROBIN_EN
    logic        last_grant_d;
`endif

    always_comb begin
        pick_d = d_access;
`ifdef OLDLAND_ARB_ROUND_ROBIN_EN
        if (i_access && d_access)
            pick_d = !last_grant_d;
`endif
    end

    // A timeout is reported as an error completion with no data.
    always_comb begin
        bus_done = m_ack || m_error || (timeout_cnt == TIMEOUT_LAST);
        bus_err  = m_error || !m_ack;
        bus_data = bus_err ? 32'd0 : m_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timeout_cnt <= 16'd0;
`ifdef OLDLAND_ARB_ROUND_ROBIN_EN
            last_grant_d <= 1'b0;
`endif
            i_data      <= 32'd0;
            i_ack       <= 1'b0;
            i_error     <= 1'b0;
            d_data      <= 32'd0;
            d_ack       <= 1'b0;
            d_error     <= 1'b0;
            m_access    <= 1'b0;
            m_addr      <= 30'd0;
            m_wr_en     <= 1'b0;
            m_bytesel   <= 4'd0;
            m_wr_val    <= 32'd0;
        end else begin
            i_ack   <= 1'b0;
            i_error <= 1'b0;
            d_ack   <= 1'b0;
            d_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_access || d_access) begin
                        timeout_cnt <= 16'd0;
                        m_access    <= 1'b1;
`ifdef OLDLAND_ARB_ROUND_ROBIN_EN
                        last_grant_d <= pick_d;
`endif
                        if (pick_d) begin
                            state     <= D_BUS;
                            m_addr    <= d_addr;
                            m_wr_en   <= d_wr_en;
                            m_bytesel <= d_bytesel;
                            m_wr_val  <= d_wr_val;
                        end else begin
                            state     <= I_BUS;
                            m_addr    <= i_addr;
                            m_wr_en   <= 1'b0;
                            m_bytesel <= 4'hf;
                            m_wr_val  <= 32'd0;
                        end
                    end
                end
                I_BUS, D_BUS: begin
                    if (bus_done) begin
                        state    <= RESP;
                        m_access <= 1'b0;
                        if (state == D_BUS) begin
                            d_ack   <= 1'b1;
                            d_error <= bus_err;
                            d_data  <= bus_data;
                        end else begin
                            i_ack   <= 1'b1;
                            i_error <= bus_err;
                            i_data  <= bus_data;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
                default: begin
                    // Requests are not sampled here; the requester drops access on seeing its ack.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
